serial_addsub_seq: RTL
======================

Name: serial_addsub_seq

Overview:
Multi-cycle add/subtract sequencer that widens the team's 2-bit add/sub datapath to WIDTH-bit operands. It processes one 2-bit digit per clock, least-significant digit first. The carry is held in a register between digits. It sits directly around the 2-bit slice: it feeds the slice its digit operands and carry, and consumes the slice's digit sum and carry. Start/busy/done handshake to the upstream controller.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2; digit count N = WIDTH/2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
op_sub  input  1  0 = a+b, 1 = a-b; captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse; result/flags valid
result  output  WIDTH  sum/difference, modulo 2^WIDTH
carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
overflow  output  1  signed overflow = carry into MSB bit XOR carry out of MSB bit

Behaviour:
- Reset: rst_n sampled low at a clk edge -> state IDLE; busy, done, result, carry_out, overflow = 0; internal operand, shift and carry registers = 0. Reset applies in every state; an in-flight operation is dropped with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> capture a, b and op_sub; carry_reg <= op_sub; digit index k <= 0; go to RUN. start=0 -> stay.
- RUN: busy=1. Each cycle compute {c, s} = a[2k+1:2k] + (b[2k+1:2k] XOR {2{op_sub}}) + carry_reg.
  - Store s as digit k of the internal result; carry_reg <= c; k <= k+1.
  - The internal carry into bit 2k+1 is kept for the overflow calculation.
  - When k = N-1: load result (all N digits), carry_out = c and overflow (from the MSB digit) into the output registers; go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE -> captures new operands and goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start sampled at edge 0 -> busy high in cycles 1..N -> done high in cycle N+1. WIDTH=8 gives done in cycle 5; the next start is accepted at the edge that ends the DONE cycle.
- start while busy=1 is ignored: not queued, and captured operands do not change. Changes on a/b/op_sub after capture have no effect.
- result, carry_out and overflow change only on the RUN->DONE transition or on reset. They hold their values through IDLE and through the next RUN until the next completion.
- WIDTH=2: a single RUN cycle; overflow is computed from bit 1.
- All arithmetic is unsigned modulo 2^WIDTH. Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.

Test Plan:
- WIDTH=8, reset then start with op_sub=0, a=0x35, b=0x4A -> busy in cycles 1-4, done pulse in cycle 5; result=0x7F, carry_out=0, overflow=0.
- op_sub=0, a=0xFF, b=0x01 -> result=0x00, carry_out=1, overflow=0. Then a=0x7F, b=0x01 -> result=0x80, carry_out=0, overflow=1.
- op_sub=1, a=0x10, b=0x20 -> result=0xF0, carry_out=0, overflow=0. Then a=0x80, b=0x01 -> result=0x7F, carry_out=1, overflow=1.
- Start a=0x01, b=0x02 (add); hold start high and change a=0xAA during cycles 1-4 -> single done in cycle 5 with result=0x03. Start is reasserted in the DONE cycle with a=0x05, b=0x03, op_sub=1 -> busy again in cycles 6-9; done in cycle 10 with result=0x02, carry_out=1.
- rst_n low in cycle 2 of an operation -> from the next cycle busy=0, done=0, result=0x00, carry_out=0, overflow=0. No done pulse follows; a fresh start after release completes normally.
- Random sweep: 1000 operations with random a, b, op_sub and idle gaps, compared against the reference model ((a ± b) mod 256, carry, signed overflow) at each done pulse. Done must arrive exactly N+1 cycles after the accepted start.

Source files
------------

// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: WIDTH-bit add/subtract built from a 2-bit digit slice.
// One digit is processed per clock, least-significant first, with the digit
// carry held in a register. Start/busy/done handshake toward the controller.
// WIDTH must be even and >= 2.

module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N     = WIDTH / 2;
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;

    localparam logic [K_W-1:0] LAST_K = K_W'(N - 1);
    localparam logic [K_W-1:0] K_ONE  = K_W'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 2-bit digit slice: returns {carry_out, carry_into_bit1, sum[1:0]}.
    // The carry into bit 1 is exposed so the MSB digit can form overflow.
    function automatic logic [3:0] add_digit(
        input logic [1:0] a_d,
        input logic [1:0] b_d,
        input logic       c_in
    );
        logic s0;
        logic s1;
        logic c1;
        logic c2;
        s0 = a_d[0] ^ b_d[0] ^ c_in;
        c1 = (a_d[0] & b_d[0]) | (a_d[0] & c_in) | (b_d[0] & c_in);
        s1 = a_d[1] ^ b_d[1] ^ c1;
        c2 = (a_d[1] & b_d[1]) | (a_d[1] & c1) | (b_d[1] & c1);
        return {c2, c1, s1, s0};
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic             busy_r;
    logic             done_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             op_sub_r;
    logic             carry_r;
    logic [K_W-1:0]   k_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_out_r;
    logic             overflow_r;

    logic             capture_s;
    logic             last_s;
    logic [1:0]       a_dig_s;
    logic [1:0]       b_dig_s;
    logic [3:0]       slice_s;
    logic [WIDTH-1:0] sum_nxt_s;

    // Operands are accepted only when no operation is in flight.
    always_comb begin
        capture_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
        last_s    = (k_r == LAST_K);
    end

    // Digit datapath: select digit k, invert B for subtract, merge the sum digit.
    always_comb begin
        a_dig_s   = a_r[{k_r, 1'b0} +: 2];
        b_dig_s   = b_r[{k_r, 1'b0} +: 2] ^ {2{op_sub_r}};
        slice_s   = add_digit(a_dig_s, b_dig_s, carry_r);
        sum_nxt_s = sum_r;
        sum_nxt_s[{k_r, 1'b0} +: 2] = slice_s[1:0];
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic; DONE accepts a new start for back-to-back operation.
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (capture_s) next_state_s = S_RUN;
                else           next_state_s = S_IDLE;
            end
            S_RUN: begin
                if (last_s) next_state_s = S_DONE;
                else        next_state_s = S_RUN;
            end
            S_DONE: begin
                if (capture_s) next_state_s = S_RUN;
                else           next_state_s = S_IDLE;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state, so busy/done come straight off flops.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (next_state_s)
            S_IDLE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            S_RUN: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            S_DONE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Operand capture, per-digit accumulation and result/flag load on the last digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            op_sub_r    <= 1'b0;
            carry_r     <= 1'b0;
            k_r         <= '0;
            sum_r       <= '0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (capture_s) begin
            a_r      <= a;
            b_r      <= b;
            op_sub_r <= op_sub;
            carry_r  <= op_sub;     // +1 of the two's-complement subtract
            k_r      <= '0;
            sum_r    <= '0;
        end else if (state_r == S_RUN) begin
            sum_r   <= sum_nxt_s;
            carry_r <= slice_s[3];
            k_r     <= k_r + K_ONE;
            if (last_s) begin
                result_r    <= sum_nxt_s;
                carry_out_r <= slice_s[3];
                overflow_r  <= slice_s[3] ^ slice_s[2];
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;

endmodule
